// File: rtl/tl_ul_arb_pkg.sv
// Shared types, widths and helpers for the two-port TL-UL arbiter.
package tl_ul_arb_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned SIZE_W = 4;
  localparam int unsigned SRC_W  = 4;
  localparam int unsigned OSRC_W = SRC_W + 1;
  localparam int unsigned ADDR_W = 31;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned DATA_W = 32;

  // A-channel opcodes
  localparam logic [OP_W-1:0] OP_PUT_FULL    = 3'd0;
  localparam logic [OP_W-1:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [OP_W-1:0] OP_GET         = 3'd4;

  // D-channel opcodes
  localparam logic [OP_W-1:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [OP_W-1:0] OP_ACCESS_ACK_DATA = 3'd1;

  // A-channel request payload of one requester
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } a_req_t;

  // Number of A beats in a message; only Puts wider than one word are multi-beat
  function automatic int unsigned beats_from_size(input logic [OP_W-1:0]   opcode,
                                                  input logic [SIZE_W-1:0] size,
                                                  input int unsigned       max_size);
    int unsigned s;
    int unsigned beats;
    s     = 32'(size);
    beats = 32'd1;
    if ((opcode == OP_PUT_FULL || opcode == OP_PUT_PARTIAL) && s > 32'd2) begin
      if (s > max_size) s = max_size;
      beats = 32'd1 << (s - 32'd2);
    end
    return beats;
  endfunction

endpackage

// File: rtl/tl_ul_arb_burst_tracker.sv
// Burst lock and stall hold for the A-channel arbiter.
// TL_UL_ARBITER_RR_EN adds the message-done strobe used by the round-robin pointer.
module tl_ul_arb_burst_tracker
  import tl_ul_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic             a_ready,
  input  logic             grant,
  input  logic [CNT_W-1:0] beats_m1,
  output logic             sticky_c,
  output logic             owner
`ifdef TL_UL_ARBITER_RR_EN
  , output logic           msg_done_c
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             hold;
  logic             a_fire;

  assign a_fire   = a_valid & a_ready;
  assign sticky_c = (state == ST_BURST) | hold;

`ifdef TL_UL_ARBITER_RR_EN
  // Last beat of a message leaves the bus this cycle
  assign msg_done_c = a_fire & ((state == ST_IDLE) ? (beats_m1 == '0)
                                                   : (beat_cnt == CNT_W'(1)));
`endif

  // Lock to the owner for a burst, or hold the grant across a stalled beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      owner    <= 1'b0;
      hold     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (a_fire) begin
            hold <= 1'b0;
            if (beats_m1 != '0) begin
              state    <= ST_BURST;
              beat_cnt <= beats_m1;
              owner    <= grant;
            end
          end else if (a_valid) begin
            hold  <= 1'b1;
            owner <= grant;
          end else begin
            hold <= 1'b0;
          end
        end
        ST_BURST: begin
          hold <= 1'b0;
          if (a_fire) begin
            beat_cnt <= beat_cnt - CNT_W'(1);
            if (beat_cnt == CNT_W'(1)) state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          hold  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tl_ul_arbiter_2.sv
// Two-requester TL-UL arbiter: unbuffered A mux with burst lock, D routing by source MSB.
// TL_UL_ARBITER_RR_EN selects round-robin tie-break; otherwise in0 has fixed priority.
module tl_ul_arbiter_2
  import tl_ul_arb_pkg::*;
#(
  parameter int unsigned MAX_SIZE = 6
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              in0_a_valid,
  output logic              in0_a_ready,
  input  logic [OP_W-1:0]   in0_a_bits_opcode,
  input  logic [SIZE_W-1:0] in0_a_bits_size,
  input  logic [SRC_W-1:0]  in0_a_bits_source,
  input  logic [ADDR_W-1:0] in0_a_bits_address,
  input  logic [MASK_W-1:0] in0_a_bits_mask,
  input  logic [DATA_W-1:0] in0_a_bits_data,
  output logic              in0_d_valid,
  input  logic              in0_d_ready,
  output logic [OP_W-1:0]   in0_d_bits_opcode,
  output logic [SIZE_W-1:0] in0_d_bits_size,
  output logic [SRC_W-1:0]  in0_d_bits_source,
  output logic              in0_d_bits_denied,
  output logic [DATA_W-1:0] in0_d_bits_data,

  input  logic              in1_a_valid,
  output logic              in1_a_ready,
  input  logic [OP_W-1:0]   in1_a_bits_opcode,
  input  logic [SIZE_W-1:0] in1_a_bits_size,
  input  logic [SRC_W-1:0]  in1_a_bits_source,
  input  logic [ADDR_W-1:0] in1_a_bits_address,
  input  logic [MASK_W-1:0] in1_a_bits_mask,
  input  logic [DATA_W-1:0] in1_a_bits_data,
  output logic              in1_d_valid,
  input  logic              in1_d_ready,
  output logic [OP_W-1:0]   in1_d_bits_opcode,
  output logic [SIZE_W-1:0] in1_d_bits_size,
  output logic [SRC_W-1:0]  in1_d_bits_source,
  output logic              in1_d_bits_denied,
  output logic [DATA_W-1:0] in1_d_bits_data,

  output logic              out_a_valid,
  input  logic              out_a_ready,
  output logic [OP_W-1:0]   out_a_bits_opcode,
  output logic [SIZE_W-1:0] out_a_bits_size,
  output logic [OSRC_W-1:0] out_a_bits_source,
  output logic [ADDR_W-1:0] out_a_bits_address,
  output logic [MASK_W-1:0] out_a_bits_mask,
  output logic [DATA_W-1:0] out_a_bits_data,

  input  logic              out_d_valid,
  output logic              out_d_ready,
  input  logic [OP_W-1:0]   out_d_bits_opcode,
  input  logic [SIZE_W-1:0] out_d_bits_size,
  input  logic [OSRC_W-1:0] out_d_bits_source,
  input  logic              out_d_bits_denied,
  input  logic [DATA_W-1:0] out_d_bits_data
);

  localparam int unsigned CNT_W = MAX_SIZE - 2;

  a_req_t           req0;
  a_req_t           req1;
  a_req_t           sel_req;
  logic             grant;
  logic             pref;
  logic             sticky;
  logic             owner;
  logic [CNT_W-1:0] beats_m1;
  logic             d_idx;

  assign req0 = '{opcode: in0_a_bits_opcode, size: in0_a_bits_size, source: in0_a_bits_source,
                  address: in0_a_bits_address, mask: in0_a_bits_mask, data: in0_a_bits_data};
  assign req1 = '{opcode: in1_a_bits_opcode, size: in1_a_bits_size, source: in1_a_bits_source,
                  address: in1_a_bits_address, mask: in1_a_bits_mask, data: in1_a_bits_data};

`ifdef TL_UL_ARBITER_RR_EN
  logic ptr;
  logic msg_done;

  // Round-robin pointer: after a message completes, prefer the other requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ptr <= 1'b0;
    else if (msg_done) ptr <= ~grant;
  end

  assign pref = ptr;
`else
  assign pref = 1'b0;
`endif

  // Grant selection: locked/held owner first, then tie-break, then the lone requester
  always_comb begin
    grant = 1'b0;
    if (sticky)                        grant = owner;
    else if (in0_a_valid && in1_a_valid) grant = pref;
    else if (in1_a_valid)              grant = 1'b1;
  end

  assign sel_req  = grant ? req1 : req0;
  assign beats_m1 = CNT_W'(beats_from_size(sel_req.opcode, sel_req.size, MAX_SIZE) - 32'd1);

  tl_ul_arb_burst_tracker #(
    .CNT_W (CNT_W)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (out_a_valid),
    .a_ready    (out_a_ready),
    .grant      (grant),
    .beats_m1   (beats_m1),
    .sticky_c   (sticky),
    .owner      (owner)
`ifdef TL_UL_ARBITER_RR_EN
    , .msg_done_c (msg_done)
`endif
  );

  // A path: zero-latency mux of the granted requester
  assign out_a_valid        = grant ? in1_a_valid : in0_a_valid;
  assign in0_a_ready        = ~grant & out_a_ready;
  assign in1_a_ready        = grant & out_a_ready;
  assign out_a_bits_opcode  = sel_req.opcode;
  assign out_a_bits_size    = sel_req.size;
  assign out_a_bits_source  = {grant, sel_req.source};
  assign out_a_bits_address = sel_req.address;
  assign out_a_bits_mask    = sel_req.mask;
  assign out_a_bits_data    = sel_req.data;

  // D path: route by the source MSB that the A path prepended
  assign d_idx       = out_d_bits_source[OSRC_W-1];
  assign in0_d_valid = out_d_valid & ~d_idx;
  assign in1_d_valid = out_d_valid & d_idx;
  assign out_d_ready = d_idx ? in1_d_ready : in0_d_ready;

  assign in0_d_bits_opcode = out_d_bits_opcode;
  assign in0_d_bits_size   = out_d_bits_size;
  assign in0_d_bits_source = out_d_bits_source[SRC_W-1:0];
  assign in0_d_bits_denied = out_d_bits_denied;
  assign in0_d_bits_data   = out_d_bits_data;
  assign in1_d_bits_opcode = out_d_bits_opcode;
  assign in1_d_bits_size   = out_d_bits_size;
  assign in1_d_bits_source = out_d_bits_source[SRC_W-1:0];
  assign in1_d_bits_denied = out_d_bits_denied;
  assign in1_d_bits_data   = out_d_bits_data;

endmodule

// File: tb/tb_tl_ul_arbiter_2.sv
// Directed bench for tl_ul_arbiter_2; covers both TL_UL_ARBITER_RR_EN builds.
module tb_tl_ul_arbiter_2;
  import tl_ul_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic        in0_a_valid, in0_a_ready, in0_d_valid, in0_d_ready, in0_d_bits_denied;
  logic [2:0]  in0_a_bits_opcode, in0_d_bits_opcode;
  logic [3:0]  in0_a_bits_size, in0_a_bits_source, in0_a_bits_mask, in0_d_bits_size, in0_d_bits_source;
  logic [30:0] in0_a_bits_address;
  logic [31:0] in0_a_bits_data, in0_d_bits_data;

  logic        in1_a_valid, in1_a_ready, in1_d_valid, in1_d_ready, in1_d_bits_denied;
  logic [2:0]  in1_a_bits_opcode, in1_d_bits_opcode;
  logic [3:0]  in1_a_bits_size, in1_a_bits_source, in1_a_bits_mask, in1_d_bits_size, in1_d_bits_source;
  logic [30:0] in1_a_bits_address;
  logic [31:0] in1_a_bits_data, in1_d_bits_data;

  logic        out_a_valid, out_a_ready, out_d_valid, out_d_ready, out_d_bits_denied;
  logic [2:0]  out_a_bits_opcode, out_d_bits_opcode;
  logic [3:0]  out_a_bits_size, out_a_bits_mask, out_d_bits_size;
  logic [4:0]  out_a_bits_source, out_d_bits_source;
  logic [30:0] out_a_bits_address;
  logic [31:0] out_a_bits_data, out_d_bits_data;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tl_ul_arbiter_2 #(.MAX_SIZE(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready),
    .in0_a_bits_opcode(in0_a_bits_opcode), .in0_a_bits_size(in0_a_bits_size),
    .in0_a_bits_source(in0_a_bits_source), .in0_a_bits_address(in0_a_bits_address),
    .in0_a_bits_mask(in0_a_bits_mask), .in0_a_bits_data(in0_a_bits_data),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready),
    .in0_d_bits_opcode(in0_d_bits_opcode), .in0_d_bits_size(in0_d_bits_size),
    .in0_d_bits_source(in0_d_bits_source), .in0_d_bits_denied(in0_d_bits_denied),
    .in0_d_bits_data(in0_d_bits_data),
    .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready),
    .in1_a_bits_opcode(in1_a_bits_opcode), .in1_a_bits_size(in1_a_bits_size),
    .in1_a_bits_source(in1_a_bits_source), .in1_a_bits_address(in1_a_bits_address),
    .in1_a_bits_mask(in1_a_bits_mask), .in1_a_bits_data(in1_a_bits_data),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready),
    .in1_d_bits_opcode(in1_d_bits_opcode), .in1_d_bits_size(in1_d_bits_size),
    .in1_d_bits_source(in1_d_bits_source), .in1_d_bits_denied(in1_d_bits_denied),
    .in1_d_bits_data(in1_d_bits_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_size(out_a_bits_size),
    .out_a_bits_source(out_a_bits_source), .out_a_bits_address(out_a_bits_address),
    .out_a_bits_mask(out_a_bits_mask), .out_a_bits_data(out_a_bits_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
    .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_size(out_d_bits_size),
    .out_d_bits_source(out_d_bits_source), .out_d_bits_denied(out_d_bits_denied),
    .out_d_bits_data(out_d_bits_data)
  );

  // Count one comparison and report it on mismatch
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive0(input logic v, input logic [2:0] op, input logic [3:0] sz,
                        input logic [3:0] src, input logic [30:0] addr);
    in0_a_valid = v; in0_a_bits_opcode = op; in0_a_bits_size = sz;
    in0_a_bits_source = src; in0_a_bits_address = addr;
    in0_a_bits_mask = 4'hf; in0_a_bits_data = 32'h0000_1000 | 32'(src);
  endtask

  task automatic drive1(input logic v, input logic [2:0] op, input logic [3:0] sz,
                        input logic [3:0] src, input logic [30:0] addr);
    in1_a_valid = v; in1_a_bits_opcode = op; in1_a_bits_size = sz;
    in1_a_bits_source = src; in1_a_bits_address = addr;
    in1_a_bits_mask = 4'h3; in1_a_bits_data = 32'h0000_2000 | 32'(src);
  endtask

  initial begin
    logic saw_in1;
    rst_n = 1'b0;
    drive0(1'b0, OP_GET, 4'd2, 4'd0, 31'd0);
    drive1(1'b0, OP_GET, 4'd2, 4'd0, 31'd0);
    out_a_ready = 1'b0; in0_d_ready = 1'b0; in1_d_ready = 1'b0;
    out_d_valid = 1'b0; out_d_bits_opcode = 3'd0; out_d_bits_size = 4'd0;
    out_d_bits_source = 5'd0; out_d_bits_denied = 1'b0; out_d_bits_data = 32'd0;

    // Reset state
    #3;
    check("rst_out_a_valid", 64'(out_a_valid), 64'd0);
    check("rst_in0_a_ready", 64'(in0_a_ready), 64'd0);
    check("rst_in1_d_valid", 64'(in1_d_valid), 64'd0);
    step();
    rst_n = 1'b1;

    // Both valid with single-beat Gets
    drive0(1'b1, OP_GET, 4'd2, 4'h5, 31'h100);
    drive1(1'b1, OP_GET, 4'd2, 4'h9, 31'h200);
    out_a_ready = 1'b1;
    #1;
    check("tie_c0_src", 64'(out_a_bits_source), 64'h05);
    check("tie_c0_addr", 64'(out_a_bits_address), 64'h100);
    check("tie_c0_in1_rdy", 64'(in1_a_ready), 64'd0);
    step();
`ifdef TL_UL_ARBITER_RR_EN
    check("rr_c1_src", 64'(out_a_bits_source), 64'h19);
    check("rr_c1_in1_rdy", 64'(in1_a_ready), 64'd1);
    check("rr_c1_data", 64'(out_a_bits_data), 64'h2009);
    check("rr_c1_mask", 64'(out_a_bits_mask), 64'h3);
    step();
    check("rr_c2_src", 64'(out_a_bits_source), 64'h05);
`else
    for (int i = 0; i < 3; i++) begin
      check("fp_src", 64'(out_a_bits_source), 64'h05);
      check("fp_in1_rdy", 64'(in1_a_ready), 64'd0);
      step();
    end
`endif
    drive0(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    drive1(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    step();

    // in1 4-beat PutFull locks out in0 until its last beat
    drive1(1'b1, OP_PUT_FULL, 4'd4, 4'h7, 31'h300);
    #1;
    check("burst_b1_src", 64'(out_a_bits_source), 64'h17);
    check("burst_b1_in1_rdy", 64'(in1_a_ready), 64'd1);
    step();
    drive0(1'b1, OP_GET, 4'd2, 4'h2, 31'h400);
    for (int b = 2; b <= 4; b++) begin
      #1;
      check("burst_in0_rdy", 64'(in0_a_ready), 64'd0);
      check("burst_in1_rdy", 64'(in1_a_ready), 64'd1);
      step();
    end
    drive1(1'b1, OP_GET, 4'd2, 4'h8, 31'h500);
    #1;
    check("burst_after_in0_rdy", 64'(in0_a_ready), 64'd1);
    check("burst_after_src", 64'(out_a_bits_source), 64'h02);
    step();
    drive0(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    drive1(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    step();

    // Stalled in0 keeps the grant when in1 arrives
    out_a_ready = 1'b0;
    drive0(1'b1, OP_GET, 4'd2, 4'h4, 31'h600);
    #1;
    check("hold0_c0_valid", 64'(out_a_valid), 64'd1);
    check("hold0_c0_src", 64'(out_a_bits_source), 64'h04);
    step();
    drive1(1'b1, OP_GET, 4'd2, 4'h6, 31'h700);
    for (int c = 1; c <= 2; c++) begin
      #1;
      check("hold0_src", 64'(out_a_bits_source), 64'h04);
      check("hold0_in1_rdy", 64'(in1_a_ready), 64'd0);
      step();
    end
    out_a_ready = 1'b1;
    #1;
    check("hold0_c3_in0_rdy", 64'(in0_a_ready), 64'd1);
    check("hold0_c3_src", 64'(out_a_bits_source), 64'h04);
    step();
    drive0(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    #1;
    check("hold0_c4_in1_rdy", 64'(in1_a_ready), 64'd1);
    step();
    drive1(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    step();

    // Stalled in1 keeps the grant when in0 arrives
    out_a_ready = 1'b0;
    drive1(1'b1, OP_GET, 4'd2, 4'hA, 31'h800);
    step();
    drive0(1'b1, OP_GET, 4'd2, 4'hB, 31'h900);
    #1;
    check("hold1_src", 64'(out_a_bits_source), 64'h1A);
    check("hold1_in0_rdy", 64'(in0_a_ready), 64'd0);
    step();
    out_a_ready = 1'b1;
    #1;
    check("hold1_in1_rdy", 64'(in1_a_ready), 64'd1);
    step();
    drive0(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    drive1(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    step();

    // D routing to in1, concurrent with an in0 A fire
    drive0(1'b1, OP_GET, 4'd2, 4'h1, 31'hA00);
    out_d_valid = 1'b1; out_d_bits_source = 5'h13; out_d_bits_data = 32'hDEAD_BEEF;
    out_d_bits_opcode = OP_ACCESS_ACK_DATA; out_d_bits_size = 4'd2;
    in1_d_ready = 1'b1; in0_d_ready = 1'b0;
    #1;
    check("d1_in1_valid", 64'(in1_d_valid), 64'd1);
    check("d1_in1_src", 64'(in1_d_bits_source), 64'h3);
    check("d1_in0_valid", 64'(in0_d_valid), 64'd0);
    check("d1_out_ready", 64'(out_d_ready), 64'd1);
    check("d1_in1_data", 64'(in1_d_bits_data), 64'hDEADBEEF);
    check("d1_in0_data", 64'(in0_d_bits_data), 64'hDEADBEEF);
    check("d1_in1_opcode", 64'(in1_d_bits_opcode), 64'(OP_ACCESS_ACK_DATA));
    check("d1_a_in0_rdy", 64'(in0_a_ready), 64'd1);
    in1_d_ready = 1'b0;
    #1;
    check("d1_out_ready_low", 64'(out_d_ready), 64'd0);
    step();
    drive0(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    out_d_bits_source = 5'h07; out_d_bits_denied = 1'b1; out_d_bits_opcode = OP_ACCESS_ACK;
    in0_d_ready = 1'b1;
    #1;
    check("d0_in0_valid", 64'(in0_d_valid), 64'd1);
    check("d0_in1_valid", 64'(in1_d_valid), 64'd0);
    check("d0_in0_src", 64'(in0_d_bits_source), 64'h7);
    check("d0_denied", 64'(in0_d_bits_denied), 64'd1);
    check("d0_out_ready", 64'(out_d_ready), 64'd1);
    step();
    out_d_valid = 1'b0; out_d_bits_denied = 1'b0; in0_d_ready = 1'b0;
    step();

    // Reset mid-burst abandons the lock immediately
    drive0(1'b1, OP_PUT_FULL, 4'd4, 4'hC, 31'hB00);
    step();
    step();
    drive0(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    drive1(1'b1, OP_GET, 4'd2, 4'hD, 31'hC00);
    rst_n = 1'b0;
    #1;
    check("rstmid_in1_rdy", 64'(in1_a_ready), 64'd1);
    check("rstmid_src", 64'(out_a_bits_source), 64'h1D);
    step();
    rst_n = 1'b1;
    #1;
    check("rstrel_in1_rdy", 64'(in1_a_ready), 64'd1);
    step();
    drive1(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    step();

    // Oversize Put clamps to 16 beats
    drive0(1'b1, OP_PUT_PARTIAL, 4'd8, 4'hE, 31'hD00);
    drive1(1'b1, OP_GET, 4'd2, 4'hF, 31'hE00);
    saw_in1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (in1_a_ready) saw_in1 = 1'b1;
      step();
    end
    check("clamp_no_in1_during_burst", 64'(saw_in1), 64'd0);
    drive0(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    #1;
    check("clamp_in1_after", 64'(in1_a_ready), 64'd1);
    step();
    drive1(1'b0, OP_GET, 4'd2, 4'h0, 31'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tl_ul_arbiter_2.md
TL_UL_ARBITER_2 -- requirements
Module: tl_ul_arbiter_2

Interface
REQ-001 Parameter: MAX_SIZE, default 6, largest legal log2 transfer size in bytes; sets the beat counter width to MAX_SIZE-2 bits.
REQ-002 clock  input  1  single clock; all state on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 in{0,1}_a_valid  input  1  requester A-channel valid.
REQ-005 in{0,1}_a_ready  output  1  requester A-channel ready.
REQ-006 in{0,1}_a_bits_opcode/size/source  input  3/4/4  TL-UL opcode, log2 size, requester-local source.
REQ-007 in{0,1}_a_bits_address/mask/data  input  31/4/32  address, byte mask, data.
REQ-008 in{0,1}_d_valid  output  1  routed response valid.
REQ-009 in{0,1}_d_ready  input  1  requester response ready.
REQ-010 in{0,1}_d_bits_opcode/size/source/denied/data  output  3/4/4/1/32  routed response fields.
REQ-011 out_a_valid, out_a_ready  output, input  1, 1  shared A-channel handshake.
REQ-012 out_a_bits_opcode/size/source/address/mask/data  output  3/4/5/31/4/32  shared A fields; source = {grant index, local source}.
REQ-013 out_d_valid, out_d_ready  input, output  1, 1  shared D-channel handshake.
REQ-014 out_d_bits_opcode/size/source/denied/data  input  3/4/5/1/32  shared response fields.

Function
REQ-015 A path SHALL be zero-latency, unbuffered: out_a_* = fields of granted requester; granted in_a_ready = out_a_ready; non-granted in_a_ready = 0.
REQ-016 Beats per message: PutFullData(0)/PutPartialData(1) with size>2 -> 2^(size-2); all other cases -> 1; size>MAX_SIZE clamps to 2^(MAX_SIZE-2).
REQ-017 State: idle (no lock) and burst (locked to owner); idle->burst on first-beat fire of a multi-beat message, beat_cnt loaded with beats-1.
REQ-018 In burst, grant = owner regardless of other valid; each fire decrements beat_cnt; fire with beat_cnt==1 returns to idle.
REQ-019 In idle with out_a_valid=1 and out_a_ready=0, grant SHALL be registered and held until fire (no grant change on stalled beat).
REQ-020 Both valid in idle, no hold: grant = requester indicated by priority pointer; one valid: grant it; none: out_a_valid=0.
REQ-021 Priority pointer SHALL update only on fire of a message's last beat, to the requester not just served.
REQ-022 D path: idx = out_d_bits_source[4]; in{idx}_d_valid = out_d_valid, other d_valid = 0; out_d_ready = in{idx}_d_ready; in_d_bits_source = out_d_bits_source[3:0]; other D fields broadcast.
REQ-023 D routing SHALL be independent of A state; simultaneous A fire and D fire both complete in the same cycle.

Reset
REQ-024 On reset assertion: state idle, beat_cnt 0, hold 0, pointer 0 (in0 preferred) immediately, not at next edge.
REQ-025 Reset mid-burst SHALL abandon the burst; first cycle after release arbitrates fresh.
REQ-026 Outputs are combinational from state and inputs; with all valids 0 after reset, out_a_valid=0 and both in_d_valid follow out_d_valid routing.

Configuration
REQ-027 Macro TL_UL_ARBITER_RR_EN defined: round-robin pointer per REQ-021.
REQ-028 Macro undefined: fixed priority, in0 always wins ties; pointer register SHALL not exist; lock/hold behaviour unchanged.

Structure
REQ-029 Package tl_ul_arb_pkg SHALL hold opcode constants (PutFull=0, PutPartial=1, Get=4, AccessAck=0, AccessAckData=1), width localparams, and the beats-from-size function.
REQ-030 One sub-module tl_ul_arb_burst_tracker SHALL own state, beat_cnt, owner, hold; arbitration mux and D routing stay in the top.

Verification
REQ-031 Both valid, Get size 2, out_a_ready=1, RR on -> in0 fires cycle 0 with out source 0x0_s; in1 fires cycle 1 with source 0x1_s.
REQ-032 in1 PutFullData size 4 (4 beats) then in0 valid at beat 2 -> in0_a_ready=0 until in1 beat 4 fires; in0 granted next cycle.
REQ-033 in0 valid, out_a_ready=0 for 3 cycles, in1 raises valid cycle 1 -> grant stays in0; in0 fires cycle 3.
REQ-034 out_d_valid with source 0x13, data 0xDEADBEEF -> in1_d_valid=1, in1_d_bits_source=0x3, in0_d_valid=0, out_d_ready tracks in1_d_ready.
REQ-035 Reset asserted after beat 2 of 4-beat Put -> after release in1 request wins immediately, no lock.
REQ-036 Macro undefined, both valid continuously with Gets -> in0 wins every cycle, in1_a_ready stays 0.
